// File: rtl/sine_pkg.sv
// Shared constants, types and the quarter-wave table generator for the I/Q sine NCO.
package sine_pkg;

    localparam int DWIDTH_DEF = 14;
    localparam int UNR_DEF    = 4;
    localparam int PWIDTH_DEF = 24;
    localparam int LUT_AW_DEF = 8;

    localparam real PI = 3.14159265358979323846;

    typedef logic [PWIDTH_DEF-1:0] phase_t;
    typedef logic signed [DWIDTH_DEF:0] lane_samples_t [UNR_DEF];

    // Entry i samples the middle of its bin, so the table never holds 0 or overflows.
    function automatic int quarter_entry(input int i, input int dw, input int aw);
        real amp;
        real ang;
        amp = real'((1 << dw) - 1);
        ang = (PI / 2.0) * (real'(i) + 0.5) / real'(1 << aw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM with a single registered read port.
module sine_quarter_lut
    import sine_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DWIDTH-1:0] data
);

    logic [DWIDTH-1:0] rom [2**LUT_AW];

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam logic [DWIDTH-1:0] ENTRY = DWIDTH'(quarter_entry(i, DWIDTH, LUT_AW));
        assign rom[i] = ENTRY;
    end

    // NOTE: the ROM read register carries no reset; validity is tracked by the caller's pipeline.
    always_ff @(posedge clk) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/sine_nco_iq.sv
// Unrolled phase-accumulator NCO producing UNR sine/cosine samples per clock, latency 3.
module sine_nco_iq
    import sine_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int UNR    = UNR_DEF,
    parameter int PWIDTH = PWIDTH_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic [PWIDTH-1:0]        fword,
    input  logic [PWIDTH-1:0]        poff,
    output logic signed [DWIDTH:0]   dout_i [UNR],
    output logic signed [DWIDTH:0]   dout_q [UNR],
    output logic                     dout_valid
);

    logic [PWIDTH-1:0] acc;
    logic              issue;
    logic [PWIDTH-1:0] lane_ph [UNR];

    logic [LUT_AW-1:0] s1_idx_i [UNR];
    logic [LUT_AW-1:0] s1_idx_q [UNR];
    logic [UNR-1:0]    s1_neg_i;
    logic [UNR-1:0]    s1_neg_q;
    logic              s1_valid;

    logic [DWIDTH-1:0] s2_mag_i [UNR];
    logic [DWIDTH-1:0] s2_mag_q [UNR];
    logic [UNR-1:0]    s2_neg_i;
    logic [UNR-1:0]    s2_neg_q;
    logic              s2_valid;

    assign issue = en && !clr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + PWIDTH'(UNR) * fword;
        end
    end

    always_comb begin
        for (int k = 0; k < UNR; k++) begin
            lane_ph[k] = acc + poff + PWIDTH'(k) * fword;
        end
    end

    // S1: quadrant decode; the cosine phase is the sine phase shifted by one quadrant.
    always_ff @(posedge clk) begin
        for (int k = 0; k < UNR; k++) begin
            logic [1:0]        q_i;
            logic [1:0]        q_q;
            logic [LUT_AW-1:0] idx;
            q_i = lane_ph[k][PWIDTH-1 -: 2];
            q_q = q_i + 2'd1;
            idx = lane_ph[k][PWIDTH-3 -: LUT_AW];
            s1_idx_i[k] <= q_i[0] ? ~idx : idx;
            s1_idx_q[k] <= q_q[0] ? ~idx : idx;
            s1_neg_i[k] <= q_i[1];
            s1_neg_q[k] <= q_q[1];
        end
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= issue;
        end
    end

    // S2: registered table reads, sign bits travel alongside.
    for (genvar k = 0; k < UNR; k++) begin : g_lane
        sine_quarter_lut #(.DWIDTH(DWIDTH), .LUT_AW(LUT_AW)) u_lut_i (
            .clk  (clk),
            .addr (s1_idx_i[k]),
            .data (s2_mag_i[k])
        );
        sine_quarter_lut #(.DWIDTH(DWIDTH), .LUT_AW(LUT_AW)) u_lut_q (
            .clk  (clk),
            .addr (s1_idx_q[k]),
            .data (s2_mag_q[k])
        );
    end

    always_ff @(posedge clk) begin
        s2_neg_i <= s1_neg_i;
        s2_neg_q <= s1_neg_q;
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    // S3: apply sign; outputs hold their last set while no valid set arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            for (int k = 0; k < UNR; k++) begin
                dout_i[k] <= '0;
                dout_q[k] <= '0;
            end
        end else begin
            dout_valid <= s2_valid;
            if (s2_valid) begin
                for (int k = 0; k < UNR; k++) begin
                    logic signed [DWIDTH:0] m_i;
                    logic signed [DWIDTH:0] m_q;
                    m_i = signed'({1'b0, s2_mag_i[k]});
                    m_q = signed'({1'b0, s2_mag_q[k]});
                    dout_i[k] <= s2_neg_i[k] ? -m_i : m_i;
                    dout_q[k] <= s2_neg_q[k] ? -m_q : m_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_nco_iq.sv
// Directed self-checking bench for sine_nco_iq with a phase-domain golden model.
module tb_sine_nco_iq;

    localparam int  UNR = 4;
    localparam real PI  = 3.14159265358979323846;

    logic               clk;
    logic               rst;
    logic               en;
    logic               clr;
    logic [23:0]        fword;
    logic [23:0]        poff;
    logic signed [14:0] dout_i [UNR];
    logic signed [14:0] dout_q [UNR];
    logic               dout_valid;

    typedef struct {
        logic [23:0] base;
        logic [23:0] fw;
    } set_t;

    set_t        sb [$];
    logic [23:0] model_acc;
    logic [2:0]  exp_pipe;
    int          last_i [UNR];
    int          last_q [UNR];
    int          n_checks;
    int          n_fail;

    sine_nco_iq dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .fword      (fword),
        .poff       (poff),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sine at the centre of the 10-bit phase bin, rounded in magnitude.
    function automatic int golden(input logic [23:0] ph);
        int  p;
        int  mag;
        real s;
        p   = int'(ph[23:14]);
        s   = $sin(2.0 * PI * (real'(p) + 0.5) / 1024.0);
        mag = $rtoi(16383.0 * (s < 0.0 ? -s : s) + 0.5);
        return (s < 0.0) ? -mag : mag;
    endfunction

    // Drive one clock of inputs, advance the model, then check outputs after the edge.
    task automatic cycle(input logic r, input logic e, input logic c);
        logic issue;
        rst = r;
        en  = e;
        clr = c;
        issue = !r && e && !c;
        if (r) begin
            exp_pipe  = '0;
            model_acc = '0;
            sb.delete();
            for (int k = 0; k < UNR; k++) begin
                last_i[k] = 0;
                last_q[k] = 0;
            end
        end else begin
            exp_pipe = {exp_pipe[1:0], issue};
            if (issue) begin
                sb.push_back('{base: model_acc + poff, fw: fword});
                model_acc = model_acc + 24'(UNR) * fword;
            end else if (c) begin
                model_acc = '0;
            end
        end
        @(negedge clk);
        check("valid", int'(dout_valid), int'(exp_pipe[2]));
        if (exp_pipe[2] && sb.size() != 0) begin
            set_t        s;
            logic [23:0] ph;
            s = sb.pop_front();
            for (int k = 0; k < UNR; k++) begin
                ph = s.base + 24'(k) * s.fw;
                last_i[k] = golden(ph);
                last_q[k] = golden(ph + 24'h400000);
            end
        end
        for (int k = 0; k < UNR; k++) begin
            check($sformatf("i%0d", k), int'(dout_i[k]), last_i[k]);
            check($sformatf("q%0d", k), int'(dout_q[k]), last_q[k]);
        end
    endtask

    task automatic check_hand(input string tag);
        int hi [UNR];
        int hq [UNR];
        hi = '{50, 16383, -50, -16383};
        hq = '{16383, -50, -16383, 50};
        for (int k = 0; k < UNR; k++) begin
            check($sformatf("%s_i%0d", tag, k), int'(dout_i[k]), hi[k]);
            check($sformatf("%s_q%0d", tag, k), int'(dout_q[k]), hq[k]);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_pipe  = '0;
        model_acc = '0;
        fword     = '0;
        poff      = '0;
        rst       = 1'b1;
        en        = 1'b0;
        clr       = 1'b0;

        // Reset, then idle with everything at zero.
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);

        // Quadrant table: one issue, result appears on the third edge.
        fword = 24'h400000;
        poff  = 24'h000000;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check_hand("quad");
        cycle(1'b0, 1'b0, 1'b0);
        check_hand("quad_hold");

        // Wrap-around: accumulator returns to zero every issue.
        repeat (4) cycle(1'b0, 1'b1, 1'b0);
        check_hand("wrap_a");
        cycle(1'b0, 1'b0, 1'b0);
        check_hand("wrap_b");
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check_hand("wrap_end");

        // Phase offset and lane continuity.
        fword = 24'h010000;
        poff  = 24'h400000;
        cycle(1'b0, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Irregular en, including clr with en high and mid-stream fword change.
        fword = 24'h02A3C1;
        poff  = 24'h123456;
        for (int n = 0; n < 40; n++) begin
            if (n == 17) begin
                cycle(1'b0, 1'b1, 1'b1);
            end else begin
                if (n == 25) fword = 24'hF0F00F;
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Reset with two sets in flight; first set afterwards starts from acc=0.
        fword = 24'h033333;
        poff  = 24'h0ABCDE;
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_nco_iq.md
Name: sine_nco_iq

Overview:
- Parametrised, pipelined successor to the combinational unrolled sine lookup.
- Each clock, an internal phase accumulator produces UNR consecutive phase samples per lane. Phase width is PWIDTH.
- A quarter-wave LUT with quadrant mirroring converts each phase sample to signed sine (I) and cosine (Q) values.
- The block feeds the parallel-sample DSP datapath: mixers and DAC serialiser.

Parameters:
- DWIDTH, 14: magnitude bits; outputs are DWIDTH+1 bits signed.
- UNR, 4: unroll factor, i.e. samples per clock.
- PWIDTH, 24: phase accumulator width, mod 2^PWIDTH.
- LUT_AW, 8: quarter-wave LUT address bits, requires PWIDTH >= LUT_AW+2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  issue UNR samples this cycle and advance the accumulator.
- clr  in  1  synchronous accumulator clear (phase re-sync).
- fword  in  PWIDTH  frequency word, i.e. phase increment per sample (unsigned).
- poff  in  PWIDTH  phase offset added to every lane.
- dout_i  out  [DWIDTH:0] x UNR  signed sine per lane.
- dout_q  out  [DWIDTH:0] x UNR  signed cosine per lane.
- dout_valid  out  1  dout_i/dout_q hold a valid sample set.

Behaviour:
- Reset (rst=1 at a clk edge):
  - acc=0.
  - All pipeline valid bits=0, so dout_valid=0.
  - All dout_i/dout_q lanes=0.
  - rst has priority over clr and en. Reset mid-stream discards in-flight samples; no valid is emitted after it.
- Accumulator and lane phases:
  - Lane k (0..UNR-1) phase: ph_k = acc + poff + k*fword, mod 2^PWIDTH.
  - Cosine phase: ph_k + 2^(PWIDTH-2).
  - When en=1 and clr=0: acc <= acc + UNR*fword (wraps silently).
  - When en=0: acc holds and nothing is issued.
  - fword and poff are sampled in the issuing cycle and take effect immediately; no glitch on change.
- clr:
  - acc <= 0; nothing is issued that cycle, even if en=1.
  - The next issuing cycle uses acc=0, so lane 0 phase = poff.
- Phase-to-amplitude mapping:
  - q = ph[PWIDTH-1:PWIDTH-2]; idx = ph[PWIDTH-3:PWIDTH-2-LUT_AW]; lower bits are truncated.
  - T[i] = round((2^DWIDTH-1) * sin(pi/2 * (i+0.5) / 2^LUT_AW)), unsigned DWIDTH bits.
  - q=0: +T[idx]; q=1: +T[~idx]; q=2: -T[idx]; q=3: -T[~idx].
  - Output is sign-extended to DWIDTH+1. Range is symmetric ±(2^DWIDTH-1), never the most negative code.
- Pipeline, fixed latency 3; throughput of one sample set per clock with no bubbles:
  - S1: register lane phases (I and Q), quadrant bits and mirrored idx.
  - S2: registered LUT read.
  - S3: apply sign and register the outputs.
  - dout_valid is high exactly 3 cycles after each issuing edge.
- dout_i/dout_q hold their last value while dout_valid=0. No backpressure.
- Lane order: lane 0 is the earliest sample in time.

Decomposition:
- Package sine_pkg:
  - Constants for default DWIDTH/PWIDTH/LUT_AW.
  - A function building the quarter-wave table T at elaboration, using the real sin/round above.
  - Typedefs: lane sample array type, phase type.
- Sub-module sine_quarter_lut:
  - One registered read port of T; DWIDTH/LUT_AW parameters.
  - Instantiated 2*UNR times (I and Q per lane) to keep the same latency.
- Top holds the accumulator, lane phase adders, quadrant logic, sign stage and valid pipeline.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles; en=0.
  - Required: dout_valid=0; all lanes 0; stays so for 10 cycles.
- Quadrant table with defaults DWIDTH=14, PWIDTH=24, LUT_AW=8, UNR=4:
  - Stimulus: clr, then fword=0x400000, poff=0, en=1 for 1 cycle.
  - Required: after 3 cycles dout_valid=1 for 1 cycle.
  - dout_i = {50, 16383, -50, -16383}.
  - dout_q = {16383, -50, -16383, 50}.
- Wrap-around:
  - Stimulus: as above with en=1 for 4 cycles.
  - Required: acc wraps to 0 each cycle (4*0x400000 = 2^24); all 4 outputs are identical to the previous set.
  - dout_valid is high for exactly 4 cycles.
- Phase offset and continuity:
  - Stimulus: fword=0x010000, poff=0x400000, en held 8 cycles.
  - Required: lane k of cycle n matches the golden model at phase 0x400000 + (4n+k)*0x010000.
  - Lane 0 of cycle n+1 continues from lane 3 of cycle n.
- Gaps and clr priority:
  - Stimulus: toggle en randomly; assert clr together with en=1.
  - Required: no sample is issued in the clr cycle; the next issued set starts at phase poff.
  - Valid gaps mirror en gaps, delayed by 3.
- Reset mid-stream:
  - Stimulus: rst=1 with 2 sample sets in flight.
  - Required: dout_valid=0 from the next edge; no stale sets emerge.
  - After release, the first set uses acc=0.
